// File: rtl/tube_pkg.sv
// Shared encodings for the Tube AHB-Lite slave: bus transfer/response codes,
// register offsets (HADDR[3:2]), status-word bit positions and the slave FSM
// state type.
package tube_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [1:0] OFS_DATA      = 2'b00;
   localparam logic [1:0] OFS_CNT       = 2'b01;

   localparam int ST_EMPTY_BIT  = 0;
   localparam int ST_FULL_BIT   = 1;
   localparam int ST_COUNT_LSB  = 8;

   typedef enum logic [1:0] {
      S_IDLE       = 2'b00,
      S_WRITE_WAIT = 2'b01,
      S_ERR1       = 2'b10,
      S_ERR2       = 2'b11
   } tube_state_e;

   // Status word: write count low byte, full and empty flags.
   function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                               input logic       full,
                                               input logic       empty);
      logic [31:0] w;
      w = '0;
      w[ST_COUNT_LSB +: 8] = cnt;
      w[ST_FULL_BIT]       = full;
      w[ST_EMPTY_BIT]      = empty;
      return w;
   endfunction

endpackage

// File: rtl/tube_fifo.sv
// Character FIFO for the Tube slave.
// Ports: clk, rst_n (synchronous, active low), push/push_data, pop,
//        full, empty, count (entries held), head (oldest entry, valid when !empty).
// Pointers carry one extra wrap bit so full/empty are distinguishable.
// A push while full is taken only if a pop happens in the same cycle.
module tube_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         push_ok;
   logic         pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ahb_tube_slave.sv
// AHB-Lite Tube slave. Byte writes to offset 0x0 are queued in a character
// FIFO and drained over char_valid/char_ready. Offset 0x0 reads return a
// status word, offset 0x4 reads/writes access a wrapping accepted-write
// counter (a write clears it).
// Ports: AHB-Lite slave signals (HCLK, HRESETn synchronous active-low, HSEL,
//        HADDR, HTRANS, HWRITE, HSIZE/HBURST/HPROT unused, HWDATA, HREADY,
//        HREADYOUT, HRESP, HRDATA) and the char stream (char_valid,
//        char_data, char_ready).
// Build option: TUBE_ERR_RESP_EN - offsets 0x8/0xC answer with a two-cycle
//        ERROR response; otherwise they read 0 and ignore writes.
//
// state        | meaning
// S_IDLE       | no data phase, or a zero-wait read / counter access
// S_WRITE_WAIT | data phase of a character write; stalls while FIFO full
// S_ERR1       | first ERROR cycle (HREADYOUT low)
// S_ERR2       | second ERROR cycle (HREADYOUT high)
module ahb_tube_slave
   import tube_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready
);

`ifdef TUBE_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   tube_state_e state_q, state_d;
   logic             dp_valid_q, dp_valid_d;
   logic             dp_write_q, dp_write_d;
   logic [1:0]       dp_ofs_q,   dp_ofs_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic                          fifo_push;
   logic                          fifo_pop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic [7:0]                    fifo_head;

   logic        addr_accept;
   logic        hreadyout_int;
   logic [1:0]  hresp_int;
   logic [31:0] hrdata_int;

   assign addr_accept = HSEL && HREADY && HTRANS[1];
   assign fifo_pop    = !fifo_empty && char_ready;
   assign char_valid  = !fifo_empty;
   assign char_data   = fifo_head;
   assign HREADYOUT   = hreadyout_int;
   assign HRESP       = hresp_int;
   assign HRDATA      = hrdata_int;

   tube_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .push      (fifo_push),
      .push_data (HWDATA[7:0]),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_comb begin
      state_d       = state_q;
      dp_valid_d    = dp_valid_q;
      dp_write_d    = dp_write_q;
      dp_ofs_d      = dp_ofs_q;
      cnt_d         = cnt_q;
      fifo_push     = 1'b0;
      hreadyout_int = 1'b1;
      hresp_int     = HRESP_OKAY;
      hrdata_int    = '0;

      case (state_q)
         S_IDLE: begin
            if (dp_valid_q && !dp_write_q) begin
               case (dp_ofs_q)
                  OFS_DATA: hrdata_int = status_word(cnt_q[7:0], fifo_full, fifo_empty);
                  OFS_CNT:  hrdata_int = {{(32-CNT_W){1'b0}}, cnt_q};
                  default:  hrdata_int = '0;
               endcase
            end else if (dp_valid_q && dp_write_q && dp_ofs_q == OFS_CNT) begin
               cnt_d = '0;
            end
         end
         S_WRITE_WAIT: begin
            // A pop in the same cycle frees the slot, so a full FIFO need not stall.
            if (!fifo_full || fifo_pop) begin
               fifo_push = 1'b1;
               cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               hreadyout_int = 1'b0;
            end
         end
         S_ERR1: begin
            hreadyout_int = 1'b0;
            hresp_int     = HRESP_ERROR;
            state_d       = S_ERR2;
         end
         S_ERR2: begin
            hresp_int = HRESP_ERROR;
         end
         default: state_d = S_IDLE;
      endcase

      // Current data phase (if any) completes: take the next address phase.
      if (hreadyout_int) begin
         dp_valid_d = addr_accept;
         dp_write_d = HWRITE;
         dp_ofs_d   = HADDR[3:2];
         if (!addr_accept)
            state_d = S_IDLE;
         else if (HADDR[3] && ERR_EN)
            state_d = S_ERR1;
         else if (HWRITE && HADDR[3:2] == OFS_DATA)
            state_d = S_WRITE_WAIT;
         else
            state_d = S_IDLE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_ofs_q   <= OFS_DATA;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_ofs_q   <= dp_ofs_d;
         cnt_q      <= cnt_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HBURST, HPROT,
                        HWDATA[31:8], fifo_count};

endmodule

// File: tb/tb_ahb_tube_slave.sv
module tb_ahb_tube_slave;

   localparam int DEPTH = 8;
`ifdef TUBE_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'b010;
   logic [2:0]  HBURST = 3'b000;
   logic [3:0]  HPROT = 4'b0011;
   logic [31:0] HWDATA = '0;
   logic        HREADY;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;

   assign HREADY = HREADYOUT;

   always #5 HCLK = ~HCLK;

   ahb_tube_slave #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL       (HSEL),
      .HADDR      (HADDR),
      .HTRANS     (HTRANS),
      .HWRITE     (HWRITE),
      .HSIZE      (HSIZE),
      .HBURST     (HBURST),
      .HPROT      (HPROT),
      .HWDATA     (HWDATA),
      .HREADY     (HREADY),
      .HREADYOUT  (HREADYOUT),
      .HRESP      (HRESP),
      .HRDATA     (HRDATA),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // char_ready source: fixed level or random per cycle
   logic cr_fixed = 1'b0;
   logic rand_cr  = 1'b0;
   always @(posedge HCLK) begin
      #2;
      char_ready = rand_cr ? 1'($urandom_range(0, 1)) : cr_fixed;
   end

   // Behavioural model: queue of characters, integer counter, pending phase.
   byte unsigned mq[$];
   int unsigned  mcnt = 0;
   bit           m_pend = 0, m_wr = 0, m_err2 = 0;
   bit [1:0]     m_ofs = 0;

   // Observations for the literal checks
   byte unsigned sunk[$];
   logic [31:0]  last_rd = '0;
   int           stall_seen = 0;
   bit           err_seen = 0;

   initial begin : compare
      bit          e_cv, pop, push, e_rdy, rst, acc, a_wr;
      bit [1:0]    a_ofs;
      logic [1:0]  e_resp;
      logic [31:0] e_rd;
      byte unsigned wd;
      @(posedge HCLK);
      forever begin
         @(negedge HCLK);
         e_cv   = (mq.size() != 0);
         pop    = e_cv && char_ready;
         push   = 0;
         e_rdy  = 1;
         e_resp = 2'b00;
         e_rd   = '0;
         if (m_pend) begin
            if (m_wr && m_ofs == 2'd0) begin
               if (mq.size() == DEPTH && !pop) e_rdy = 0;
               else push = 1;
            end else if (m_ofs[1] && ERR_EN) begin
               e_resp = 2'b01;
               e_rdy  = m_err2;
            end else if (!m_wr) begin
               if (m_ofs == 2'd0)
                  e_rd = ((mcnt % 256) * 256) + ((mq.size() == DEPTH) ? 2 : 0) + ((mq.size() == 0) ? 1 : 0);
               else if (m_ofs == 2'd1)
                  e_rd = mcnt;
            end
         end
         check("hreadyout", HREADYOUT, e_rdy);
         check("hresp", HRESP, e_resp);
         check("hrdata", HRDATA, e_rd);
         check("char_valid", char_valid, e_cv);
         if (e_cv) check("char_data", char_data, mq[0]);
         if (!e_rdy) stall_seen++;
         if (e_resp == 2'b01) err_seen = 1;
         if (m_pend && !m_wr && e_resp == 2'b00) last_rd = HRDATA;
         if (char_valid && char_ready) sunk.push_back(char_data);
         rst   = HRESETn;
         acc   = HSEL && e_rdy && HTRANS[1];
         a_wr  = HWRITE;
         a_ofs = HADDR[3:2];
         wd    = HWDATA[7:0];
         @(posedge HCLK);
         if (!rst) begin
            mq.delete();
            mcnt = 0; m_pend = 0; m_err2 = 0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
               mq.push_back(wd);
               mcnt = (mcnt + 1) % 65536;
            end
            if (m_pend && m_wr && m_ofs == 2'd1) mcnt = 0;
            if (m_pend && m_ofs[1] && ERR_EN && !m_err2) m_err2 = 1;
            else if (e_rdy) begin
               m_pend = acc; m_wr = a_wr; m_ofs = a_ofs; m_err2 = 0;
            end
         end
      end
   end

   // Present one address phase, hold it until accepted, then drive its data.
   task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] addr, input logic [7:0] d);
      logic r;
      int   n;
      HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = addr;
      r = 0; n = 0;
      while (!r && n < 200) begin
         @(negedge HCLK);
         r = HREADYOUT;
         @(posedge HCLK);
         n++;
      end
      check("xfer_accept_timeout", r, 1'b1);
      #1;
      HWDATA = {24'hA5C3E1, d};
      HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      HRESETn = 0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1;
      @(negedge HCLK);
      check("rst_hreadyout", HREADYOUT, 1'b1);
      check("rst_hresp", HRESP, 2'b00);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_char_valid", char_valid, 1'b0);
      @(posedge HCLK); #1;

      // 1: single write, drained immediately
      cr_fixed = 1;
      xfer(1, 2'b10, 1, 32'h2000_0000, 8'h45);
      idle(3);
      check("t1_count", sunk.size(), 1);
      check("t1_char", sunk[0], 8'h45);

      // 2: overfill by one with sink blocked
      sunk.delete();
      cr_fixed = 0;
      stall_seen = 0;
      for (int i = 0; i < 9; i++) xfer(1, 2'b10, 1, 32'h2000_0000, 8'(8'h30 + i));
      idle(3);
      @(negedge HCLK);
      check("t2_stalled", HREADYOUT, 1'b0);
      @(posedge HCLK); #1;
      check("t2_stall_seen", (stall_seen > 0), 1'b1);
      cr_fixed = 1;
      idle(15);
      check("t2_drained", sunk.size(), 9);
      for (int i = 0; i < 9; i++) check("t2_order", sunk[i], 8'(8'h30 + i));

      // 3: status and counter registers
      cr_fixed = 0;
      xfer(1, 2'b10, 1, 32'h2000_0004, 8'h00);
      for (int i = 0; i < 3; i++) xfer(1, 2'b10, 1, 32'h2000_0000, 8'(8'h61 + i));
      xfer(1, 2'b10, 0, 32'h2000_0000, 8'h00);
      idle(1);
      check("t3_status", last_rd, 32'h0000_0300);
      xfer(1, 2'b10, 0, 32'h2000_0004, 8'h00);
      idle(1);
      check("t3_cnt", last_rd, 32'h3);
      xfer(1, 2'b10, 1, 32'h2000_0004, 8'h00);
      xfer(1, 2'b10, 0, 32'h2000_0004, 8'h00);
      idle(1);
      check("t3_cnt_clr", last_rd, 32'h0);
      cr_fixed = 1;
      idle(6);

      // 4: reserved offsets
      xfer(1, 2'b10, 1, 32'h2000_0000, 8'h7A);
      err_seen = 0;
      last_rd = 32'hDEAD_BEEF;
      xfer(1, 2'b10, 0, 32'h2000_0008, 8'h00);
      idle(3);
`ifdef TUBE_ERR_RESP_EN
      check("t4_err_seen", err_seen, 1'b1);
      check("t4_no_rdata", last_rd, 32'hDEAD_BEEF);
`else
      check("t4_err_seen", err_seen, 1'b0);
      check("t4_rdata", last_rd, 32'h0);
`endif
      xfer(1, 2'b10, 1, 32'h2000_000C, 8'h55);
      xfer(1, 2'b10, 0, 32'h2000_0004, 8'h00);
      idle(1);
      check("t4_cnt_kept", last_rd, 32'h1);

      // 5: transfers that must not push
      sunk.delete();
      xfer(1, 2'b00, 1, 32'h2000_0000, 8'h71);
      xfer(1, 2'b01, 1, 32'h2000_0000, 8'h72);
      xfer(0, 2'b10, 1, 32'h2000_0000, 8'h73);
      idle(2);
      check("t5_no_push", sunk.size(), 0);
      xfer(1, 2'b10, 0, 32'h2000_0004, 8'h00);
      idle(1);
      check("t5_cnt", last_rd, 32'h1);

      // 6: reset during full stall
      cr_fixed = 0;
      for (int i = 0; i < 9; i++) xfer(1, 2'b10, 1, 32'h2000_0000, 8'(8'h40 + i));
      idle(1);
      @(negedge HCLK);
      check("t6_stalled", HREADYOUT, 1'b0);
      @(posedge HCLK); #1 HRESETn = 0;
      @(posedge HCLK); #1 HRESETn = 1;
      @(negedge HCLK);
      check("t6_hreadyout", HREADYOUT, 1'b1);
      check("t6_char_valid", char_valid, 1'b0);
      @(posedge HCLK); #1;
      xfer(1, 2'b10, 0, 32'h2000_0004, 8'h00);
      idle(1);
      check("t6_cnt", last_rd, 32'h0);

      // Randomized traffic against the model
      rand_cr = 1;
      for (int i = 0; i < 400; i++) begin
         logic        sel, wr;
         logic [1:0]  tr, ofs;
         int          r;
         sel = ($urandom_range(0, 9) != 0);
         tr  = 2'($urandom_range(0, 3));
         wr  = ($urandom_range(0, 3) != 0);
         r   = $urandom_range(0, 19);
         ofs = (r < 14) ? 2'd0 : (r < 17) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
         xfer(sel, tr, wr, {28'h2000_000, ofs, 2'b00}, 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
      end
      rand_cr = 0;
      cr_fixed = 1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
